song_sequencer: RTL and testbench

- Plays songs out of `song_rom`, one entry at a time.
- Drives `rom_addr` and absorbs the ROM's 1-cycle registered read. Decodes each 16-bit entry `{rest, note[5:0], duration[5:0], 3'b0}`.
- Holds each decoded note for `duration` beat ticks, then fetches the next entry.
- Sits between the song ROM and the note player / tone generator. The top level drives it with play, song select, restart and the beat tick.

---
 rtl/song_pkg.sv | 35 +++
 rtl/song_sequencer_note_timer.sv | 27 ++
 rtl/song_sequencer.sv | 145 ++++++++++++++
 tb/tb_song_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: ROM entry layout, FSM states and the entry decoder.
package song_pkg;

  localparam int unsigned ROM_DATA_W = 16;
  localparam int unsigned ROM_ADDR_W = 7;
  localparam int unsigned REST_BIT   = 15;
  localparam int unsigned NOTE_MSB   = 14;
  localparam int unsigned NOTE_LSB   = 9;
  localparam int unsigned DUR_MSB    = 8;
  localparam int unsigned DUR_LSB    = 3;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StPlay,
    StDone
  } state_e;

  typedef struct packed {
    logic                       rest;
    logic [NOTE_MSB-NOTE_LSB:0] note;
    logic [DUR_MSB-DUR_LSB:0]   dur;
  } entry_t;

  // Takes only the meaningful upper bits; the low padding bits never reach the decoder.
  function automatic entry_t decode_entry(logic [ROM_DATA_W-1:DUR_LSB] word);
    entry_t e;
    e.rest = word[REST_BIT];
    e.note = word[NOTE_MSB:NOTE_LSB];
    e.dur  = word[DUR_MSB:DUR_LSB];
    return e;
  endfunction

endpackage

// File: rtl/song_sequencer_note_timer.sv
// Loadable beat down-counter; expire flags the beat that ends the current note.
module note_timer #(
  parameter int unsigned DUR_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [DUR_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expire = en && (count_q == DUR_W'(1));

endmodule

// File: rtl/song_sequencer.sv
// Walks a song in the ROM entry by entry, holding each decoded note for its duration in beats.
module song_sequencer
  import song_pkg::*;
#(
  parameter int unsigned SONG_SEL_W = 2,
  parameter int unsigned ENTRY_W    = 5,
  parameter int unsigned NOTE_W     = 6,
  parameter int unsigned DUR_W      = 6
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          play,
  input  logic [SONG_SEL_W-1:0]         song,
  input  logic                          restart,
  input  logic                          beat,
  output logic [SONG_SEL_W+ENTRY_W-1:0] rom_addr,
  input  logic [ROM_DATA_W-1:0]         rom_dout,
  output logic [NOTE_W-1:0]             note,
  output logic [DUR_W-1:0]              duration,
  output logic                          is_rest,
  output logic                          new_note,
  output logic                          note_active,
  output logic                          song_done
);

  state_e                state_q;
  logic [SONG_SEL_W-1:0] song_q;
  logic [ENTRY_W-1:0]    index_q;
  logic [NOTE_W-1:0]     note_q;
  logic [DUR_W-1:0]      dur_q;
  logic                  rest_q;
  logic                  new_note_q;
  logic                  song_done_q;

  entry_t entry;
  logic   reseek;
  logic   timer_load;
  logic   timer_en;
  logic   expire;
  logic   unused_rom_bits;

  assign entry           = decode_entry(rom_dout[ROM_DATA_W-1:DUR_LSB]);
  assign unused_rom_bits = ^rom_dout[DUR_LSB-1:0];
  assign reseek          = restart || (song != song_q);

  // The beat coinciding with new_note is dropped: the timer was only just loaded.
  assign timer_load = (state_q == StWait) && !reseek && (entry.dur != '0);
  assign timer_en   = (state_q == StPlay) && beat && play && !new_note_q && !reseek;

  note_timer #(
    .DUR_W(DUR_W)
  ) u_note_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .load_val(entry.dur),
    .en      (timer_en),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      song_q      <= '0;
      index_q     <= '0;
      note_q      <= '0;
      dur_q       <= '0;
      rest_q      <= 1'b1;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (play) begin
            song_q  <= song;
            index_q <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          // A reseek here must refetch: the ROM already sampled the stale address.
          if (reseek) begin
            song_q  <= song;
            index_q <= '0;
            state_q <= StFetch;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (reseek) begin
            song_q  <= song;
            index_q <= '0;
            state_q <= StFetch;
          end else if (entry.dur == '0) begin
            song_done_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            note_q     <= entry.note;
            dur_q      <= entry.dur;
            rest_q     <= entry.rest;
            new_note_q <= 1'b1;
            state_q    <= StPlay;
          end
        end
        StPlay: begin
          if (reseek) begin
            song_q  <= song;
            index_q <= '0;
            state_q <= StFetch;
          end else if (expire) begin
            if (index_q == {ENTRY_W{1'b1}}) begin
              song_done_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              index_q <= index_q + 1'b1;
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          if (!play) begin
            state_q <= StIdle;
          end else if (reseek) begin
            song_q  <= song;
            index_q <= '0;
            state_q <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rom_addr    = {song_q, index_q};
  assign note        = note_q;
  assign duration    = dur_q;
  assign is_rest     = rest_q;
  assign new_note    = new_note_q;
  assign song_done   = song_done_q;
  assign note_active = (state_q == StPlay) && play;

endmodule

// File: tb/tb_song_sequencer.sv
// Randomized bench for song_sequencer: a beat-counting song model feeds a queue of expected events.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        play = 1'b0;
  logic [1:0]  song = '0;
  logic        restart = 1'b0;
  logic        beat = 1'b0;
  logic [6:0]  rom_addr;
  logic [15:0] rom_dout;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        is_rest;
  logic        new_note;
  logic        note_active;
  logic        song_done;

  song_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .play       (play),
    .song       (song),
    .restart    (restart),
    .beat       (beat),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .note       (note),
    .duration   (duration),
    .is_rest    (is_rest),
    .new_note   (new_note),
    .note_active(note_active),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;

  logic [15:0] rom_mem [128];
  always @(posedge clk) rom_dout <= rom_mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    bit         is_done;
    logic [6:0] addr;
    logic [5:0] note;
    logic [5:0] dur;
    logic       rest;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Song model: idle / running / done, plus the fetch and beat bookkeeping of the current note.
  int         m_mode = 0;
  logic [1:0] m_song = '0;
  int         m_idx = 0;
  int         fs = -10;
  int         done_at = -1;
  int         note_start = -10;
  int         beats_left = 0;
  int         m_done_cnt = 0;
  bit         exp_active = 1'b0;

  logic [5:0] held_note = '0;
  logic [5:0] held_dur = '0;
  logic       held_rest = 1'b1;

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic start_fetch(input int f);
    logic [15:0] w;
    exp_t        e;
    w       = rom_mem[{m_song, m_idx[4:0]}];
    fs      = f;
    e.due   = f + 2;
    e.addr  = {m_song, m_idx[4:0]};
    e.note  = w[14:9];
    e.dur   = w[8:3];
    e.rest  = w[15];
    if (w[8:3] == 6'd0) begin
      e.is_done = 1'b1;
      done_at   = f + 2;
    end else begin
      e.is_done  = 1'b0;
      note_start = f + 2;
      beats_left = int'(w[8:3]);
    end
    expq.push_back(e);
  endtask

  task automatic model_cycle(input int t);
    bit   reseek;
    exp_t e;
    if (m_mode == 1 && done_at >= 0 && t >= done_at) begin
      m_mode  = 2;
      done_at = -1;
      m_done_cnt++;
    end
    exp_active = (m_mode == 1 && t >= fs + 2) && play;
    reseek     = restart || (song != m_song);
    case (m_mode)
      0: if (play) begin
        m_song = song;
        m_idx  = 0;
        m_mode = 1;
        start_fetch(t + 1);
      end
      1: if (reseek) begin
        while (expq.size() > 0 && expq[$].due > t) void'(expq.pop_back());
        done_at = -1;
        m_song  = song;
        m_idx   = 0;
        start_fetch(t + 1);
      end else if (t >= fs + 2 && beat && play && t != note_start) begin
        beats_left--;
        if (beats_left == 0) begin
          if (m_idx == 31) begin
            e.due     = t + 1;
            e.is_done = 1'b1;
            e.addr    = {m_song, 5'd31};
            e.note    = '0;
            e.dur     = '0;
            e.rest    = 1'b0;
            expq.push_back(e);
            done_at = t + 1;
          end else begin
            m_idx++;
            start_fetch(t + 1);
          end
        end
      end
      default: if (!play) begin
        m_mode = 0;
      end else if (reseek) begin
        m_song = song;
        m_idx  = 0;
        m_mode = 1;
        start_fetch(t + 1);
      end
    endcase
  endtask

  task automatic drive(input bit p, input logic [1:0] s, input bit r, input bit b);
    @(posedge clk);
    #1;
    play    = p;
    song    = s;
    restart = r;
    beat    = b;
    model_cycle(cyc);
  endtask

  task automatic run_until_done(input logic [1:0] s, input int play_pct, input int budget,
                                input string tag);
    int start_cnt;
    start_cnt = m_done_cnt;
    for (int i = 0; i < budget && m_done_cnt == start_cnt; i++) drive(pct(play_pct), s, 0, pct(50));
    n_cmp++;
    if (m_done_cnt == start_cnt) begin
      n_err++;
      $display("FAIL %s_timeout: got no song end within %0d cycles, expected one", tag, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"}, int'(rom_addr), 0);
    check({tag, "_note"}, int'(note), 0);
    check({tag, "_duration"}, int'(duration), 0);
    check({tag, "_is_rest"}, int'(is_rest), 1);
    check({tag, "_new_note"}, int'(new_note), 0);
    check({tag, "_note_active"}, int'(note_active), 0);
    check({tag, "_song_done"}, int'(song_done), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals an event, checks held outputs each cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held_note = '0;
        held_dur  = '0;
        held_rest = 1'b1;
        continue;
      end
      while (expq.size() > 0 && expq[0].due < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_event: got nothing by cycle %0d, expected %s at cycle %0d (addr %0d)",
                 cyc, expq[0].is_done ? "song_done" : "new_note", expq[0].due, expq[0].addr);
        void'(expq.pop_front());
      end
      n_cmp++;
      if (new_note && song_done) begin
        n_err++;
        $display("FAIL exclusive_pulses: got new_note=1 song_done=1 at cycle %0d, expected not both",
                 cyc);
      end
      if (new_note || song_done) begin
        n_cmp++;
        if (expq.size() == 0 || expq[0].due != cyc) begin
          n_err++;
          $display("FAIL unexpected_event: got new_note=%0b song_done=%0b at cycle %0d, expected none",
                   new_note, song_done, cyc);
        end else begin
          e = expq.pop_front();
          check("event_kind_song_done", int'(song_done), int'(e.is_done));
          check("event_rom_addr", int'(rom_addr), int'(e.addr));
          if (!e.is_done) begin
            held_note = e.note;
            held_dur  = e.dur;
            held_rest = e.rest;
          end
        end
      end
      check("note_active", int'(note_active), int'(exp_active));
      check("held_note", int'(note), int'(held_note));
      check("held_duration", int'(duration), int'(held_dur));
      check("held_is_rest", int'(is_rest), int'(held_rest));
    end
  end

  initial begin : driver
    logic [15:0] w;
    bit          hit;
    for (int a = 0; a < 128; a++) begin
      w      = 16'($urandom);
      w[8:3] = 6'($urandom_range(1, 3));
      rom_mem[a] = w;
    end
    rom_mem[0]  = {1'b0, 6'd28, 6'd12, 3'b101};
    w           = rom_mem[28];
    w[8:3]      = 6'd0;
    rom_mem[28] = w;
    rom_mem[32] = {1'b1, 6'd0, 6'd12, 3'b010};
    w           = rom_mem[42];
    w[8:3]      = 6'd0;
    rom_mem[42] = w;
    w           = rom_mem[101];
    w[8:3]      = 6'd0;
    rom_mem[101] = w;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) drive(0, 0, 0, 1);

    // Song 0: long first note, end marker at entry 28.
    run_until_done(2'd0, 100, 3000, "song0");
    repeat (3) drive(0, 0, 0, 0);

    // Song 1 with pauses, then switch to song 0 mid-play.
    for (int i = 0; i < 80; i++) drive(pct(80), 2'd1, 0, pct(50));
    drive(1, 2'd0, 0, 0);
    run_until_done(2'd0, 80, 3000, "song1_to_0");
    repeat (3) drive(0, 0, 0, 0);

    // Song 2 has no end marker: must stop after entry 31 without wrapping.
    run_until_done(2'd2, 100, 3000, "song2");
    repeat (3) drive(1, 2'd2, 0, 1);
    #2;
    check("no_wrap_rom_addr", int'(rom_addr), 95);
    repeat (2) drive(0, 2'd2, 0, 0);

    // Restart on the very beat that would end a note.
    hit = 1'b0;
    drive(1, 2'd2, 0, 0);
    for (int i = 0; i < 600 && !hit; i++) begin
      if (m_mode == 1 && done_at < 0 && cyc + 1 >= fs + 2 && beats_left == 1 &&
          cyc + 1 != note_start) begin
        hit = 1'b1;
        drive(1, 2'd2, 1, 1);
      end else begin
        drive(1, 2'd2, 0, pct(50));
      end
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL restart_on_last_beat: got no final-beat cycle within 600 cycles, expected one");
    end
    for (int i = 0; i < 20; i++) drive(1, 2'd2, 0, pct(50));

    // Random mix of play, song changes, restarts and beats.
    begin
      bit         p;
      logic [1:0] s;
      p = 1'b1;
      s = 2'd2;
      for (int i = 0; i < 1500; i++) begin
        if (pct(6)) p = ~p;
        if (pct(2)) s = 2'($urandom_range(3));
        drive(p, s, pct(3), pct(50));
      end
    end

    // Asynchronous reset while a note is playing, then resume on song 3.
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      drive(1, 2'd3, 0, pct(50));
      if (m_mode == 1 && cyc >= fs + 2) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL reach_play: got no note playing within 400 cycles, expected one");
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    expq.delete();
    m_mode     = 0;
    m_song     = '0;
    done_at    = -1;
    exp_active = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    play    = 1'b1;
    song    = 2'd3;
    restart = 1'b0;
    beat    = 1'b0;
    model_cycle(cyc);
    run_until_done(2'd3, 100, 2000, "song3_after_reset");

    repeat (10) drive(0, 2'd3, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
